// File: rtl/if_stage.sv
// Instruction fetch stage: PC register, fetch handshake FSM with skid buffer and
// pending-redirect drain, and the IF/ID pipeline register.
module if_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        PCWrite,
    input  logic        stall_IF_ID,
    input  logic        flush_IF_ID,
    input  logic        Branch_taken_ID,
    input  logic [31:0] branch_target_ID,
    input  logic        Jump_MEM,
    input  logic [31:0] jump_target_MEM,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instr_ID,
    output logic [31:0] pc_ID,
    output logic [31:0] pc4_ID,
    output logic        valid_ID,
    output logic        fetch_busy
);

    typedef enum logic [1:0] {
        FETCH   = 2'd0,
        WAIT_RD = 2'd1,
        HELD    = 2'd2,
        DRAIN   = 2'd3
    } state_t;

    state_t      state, state_next;
    logic [31:0] pc, pc_next;
    logic [31:0] skid_data, skid_data_next;
    logic        skid_valid, skid_valid_next;
    logic [31:0] pend_target, pend_target_next;
    logic        pend_valid, pend_valid_next;
    logic [31:0] instr_next, pc_id_next, pc4_id_next;
    logic        valid_next;

    logic        hold;
    logic        redirect;
    logic [31:0] target;
    logic [31:0] pc_plus4;

    assign hold     = stall_IF_ID | ~PCWrite;
    assign redirect = Jump_MEM | Branch_taken_ID;
    assign target   = (Jump_MEM ? jump_target_MEM : branch_target_ID) & ~32'h3;
    assign pc_plus4 = pc + 32'd4;

    assign imem_addr  = pc;
    assign imem_req   = ~rst & (state != HELD);
    assign fetch_busy = ~rst & ((state == WAIT_RD) | (state == DRAIN));

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= FETCH;
            pc          <= RESET_PC & ~32'h3;
            skid_data   <= 32'h0;
            skid_valid  <= 1'b0;
            pend_target <= 32'h0;
            pend_valid  <= 1'b0;
            instr_ID    <= NOP_INSTR;
            pc_ID       <= 32'h0;
            pc4_ID      <= 32'h0;
            valid_ID    <= 1'b0;
        end else begin
            state       <= state_next;
            pc          <= pc_next;
            skid_data   <= skid_data_next;
            skid_valid  <= skid_valid_next;
            pend_target <= pend_target_next;
            pend_valid  <= pend_valid_next;
            instr_ID    <= instr_next;
            pc_ID       <= pc_id_next;
            pc4_ID      <= pc4_id_next;
            valid_ID    <= valid_next;
        end
    end

    // PC and fetch-handshake sequencing; a request is never abandoned while
    // memory still owes data, so redirects during a wait go through DRAIN.
    always_comb begin
        state_next       = state;
        pc_next          = pc;
        skid_data_next   = skid_data;
        skid_valid_next  = skid_valid;
        pend_target_next = pend_target;
        pend_valid_next  = pend_valid;
        case (state)
            FETCH, WAIT_RD: begin
                if (redirect) begin
                    skid_valid_next = 1'b0;
                    if (imem_ready) begin
                        pc_next    = target;
                        state_next = FETCH;
                    end else begin
                        pend_target_next = target;
                        pend_valid_next  = 1'b1;
                        state_next       = DRAIN;
                    end
                end else if (imem_ready) begin
                    if (hold) begin
                        skid_data_next  = imem_rdata;
                        skid_valid_next = 1'b1;
                        state_next      = HELD;
                    end else begin
                        pc_next    = pc_plus4;
                        state_next = FETCH;
                    end
                end else begin
                    state_next = WAIT_RD;
                end
            end
            HELD: begin
                if (redirect) begin
                    pc_next         = target;
                    skid_valid_next = 1'b0;
                    state_next      = FETCH;
                end else if (!hold) begin
                    pc_next         = pc_plus4;
                    skid_valid_next = 1'b0;
                    state_next      = FETCH;
                end
            end
            DRAIN: begin
                if (redirect) begin
                    pend_target_next = target;
                    pend_valid_next  = 1'b1;
                end
                if (imem_ready) begin
                    if (redirect) begin
                        pc_next = target;
                    end else if (pend_valid) begin
                        pc_next = pend_target;
                    end
                    pend_valid_next = 1'b0;
                    state_next      = FETCH;
                end
            end
            default: begin
                state_next = FETCH;
            end
        endcase
    end

    // IF/ID register: a bubble keeps pc_ID/pc4_ID and only replaces the word.
    always_comb begin
        instr_next  = instr_ID;
        pc_id_next  = pc_ID;
        pc4_id_next = pc4_ID;
        valid_next  = valid_ID;
        if (redirect || flush_IF_ID) begin
            instr_next = NOP_INSTR;
            valid_next = 1'b0;
        end else if (!hold) begin
            case (state)
                FETCH, WAIT_RD: begin
                    if (imem_ready) begin
                        instr_next  = imem_rdata;
                        pc_id_next  = pc;
                        pc4_id_next = pc_plus4;
                        valid_next  = 1'b1;
                    end else begin
                        instr_next = NOP_INSTR;
                        valid_next = 1'b0;
                    end
                end
                HELD: begin
                    instr_next  = skid_data;
                    pc_id_next  = pc;
                    pc4_id_next = pc_plus4;
                    valid_next  = skid_valid;
                end
                default: begin
                    instr_next = NOP_INSTR;
                    valid_next = 1'b0;
                end
            endcase
        end
    end

endmodule
